input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Parametrised N-channel input conditioner between the keyboard/button decoders and the
//   game FSM. Synchronises raw level inputs and emits one-clk command pulses.
//   Each channel runs one-shot or DAS auto-repeat, with delay and repeat rate set at runtime.
//   Optional SOCD (last-pressed-wins) resolution on channels 0/1 (left/right), plus a freeze
//   input for pause and menus.
// PARAMETERS
//   NUM_CH       8          number of input channels
//   TIMER_W      6          width of per-channel tick counter and cfg_* ports
//   SYNC_STAGES  2          flop stages on each raw input (>=1)
//   REPEAT_MASK  8'b0000_0111  bit i=1: channel i is DAS-repeat; bit i=0: channel i is one-shot
//   SOCD_EN      1          1: apply last-pressed-wins to channels 0 and 1
// PORTS
//   clk            in   1         system clock
//   rst            in   1         synchronous, active-high reset
//   tick           in   1         one-clk frame strobe (60 Hz)
//   freeze         in   1         1: suppress all commands and return channels to IDLE
//   cfg_das_delay  in   TIMER_W   ticks from initial press to first repeat (0 treated as 1)
//   cfg_arr        in   TIMER_W   ticks between repeats (0 treated as 1)
//   raw_in         in   NUM_CH    raw active-high key levels, asynchronous
//   cmd_pulse      out  NUM_CH    one-clk command pulses, registered
//   held           out  NUM_CH    effective (post-sync, post-SOCD) level, registered
// BEHAVIOUR
//   Reset: sync chain, prev, held, cmd_pulse, counters all 0; every channel state IDLE.
//   sync[i]: raw_in[i] after SYNC_STAGES flops.
//   eff[i]:  sync[i] gated by SOCD; eff[i] drives held[i] on the next clk.
//   rise[i] = eff[i] & ~prev[i]; prev[i] <= eff[i] every clk, including while freeze=1.
//   Latency: a raw edge reaches cmd_pulse/held SYNC_STAGES+1 clks later.
//   All cmd_pulse bits default 0 each clk and are high for exactly one clk.
//   One-shot channel: cmd_pulse[i] <= rise[i] & ~freeze.
//   Repeat channel FSM, counter cnt of TIMER_W bits:
//     IDLE:   rise -> pulse, cnt=0, go to DELAY.
//     DELAY:  on tick, if cnt+1 >= max(cfg_das_delay,1) -> pulse, cnt=0, go to REPEAT;
//             otherwise cnt++.
//     REPEAT: on tick, if cnt+1 >= max(cfg_arr,1) -> pulse, cnt=0; otherwise cnt++.
//     From any state, eff=0 -> IDLE and cnt=0 in the same clk, with no pulse.
//     rise in the same clk as tick: the rise wins and the tick is not counted.
//     cfg_* are sampled live every clk. Because the compare is >=, lowering a cfg value
//       mid-hold fires on the next tick.
//     cnt+1 is computed TIMER_W+1 bits wide, so the counter never wraps.
//   SOCD (SOCD_EN=1, NUM_CH>=2): a register owner tracks the last-pressed of channels 0/1.
//     - Both sync high: only the owner is eff; the loser sees eff=0 and drops to IDLE.
//     - Both rise in the same clk: channel 0 wins.
//     - Owner released while the loser is still held: the loser becomes eff next clk,
//       which counts as a fresh rise (pulse, then DELAY).
//     - SOCD_EN=0: eff = sync for all channels.
//   freeze=1:
//     - cmd_pulse forced 0; all repeat FSMs go to IDLE with cnt=0.
//     - held keeps tracking eff.
//     - A key still held when freeze drops produces no pulse until it is re-pressed.
//   rst asserted mid-hold: all state clears the next clk.
//     - A key still held after rst releases produces a rise and a pulse, because prev=0.
// TESTING
//   1. REPEAT_MASK bit 0 set, das=10, arr=2; hold ch0 for 20 ticks
//      -> pulses at press, at tick 10, then ticks 12,14,16,18,20 (7 total); release -> none.
//   2. One-shot ch4 held 100 ticks -> exactly 1 pulse; release and re-press -> 1 more pulse.
//   3. SOCD: hold ch0, then press ch1 at tick 3
//      -> ch1 pulses, held=2'b10, ch0 stops repeating.
//      Release ch1 at tick 8 -> ch0 pulses next clk, restarts DELAY.
//   4. ch0 and ch1 rise in the same clk -> only ch0 pulses, held=2'b01.
//   5. Freeze during ch0 REPEAT -> no pulses, held[0]=1.
//      Unfreeze with key held -> no pulse. Re-press -> pulse.
//   6. cfg_arr=0 -> pulse every tick in REPEAT.
//      Change cfg_das_delay 30->5 at cnt=8 in DELAY -> pulse on next tick.
//      rise coincident with tick -> cnt=0.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Command-side bundle of the input conditioner: frame strobe, freeze, timing config,
// raw key levels in; command pulses and effective held levels out.
interface input_conditioner_if #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned TIMER_W = 6
);
    logic               tick;
    logic               freeze;
    logic [TIMER_W-1:0] cfg_das_delay;
    logic [TIMER_W-1:0] cfg_arr;
    logic [NUM_CH-1:0]  raw_in;
    logic [NUM_CH-1:0]  cmd_pulse;
    logic [NUM_CH-1:0]  held;

    modport master (
        output tick,
        output freeze,
        output cfg_das_delay,
        output cfg_arr,
        output raw_in,
        input  cmd_pulse,
        input  held
    );

    modport slave (
        input  tick,
        input  freeze,
        input  cfg_das_delay,
        input  cfg_arr,
        input  raw_in,
        output cmd_pulse,
        output held
    );
endinterface

// File: rtl/input_conditioner.sv
// N-channel key conditioner: synchronises raw levels, resolves left/right SOCD and
// turns presses into one-clk command pulses, one-shot or DAS auto-repeat per channel.
module input_conditioner #(
    parameter int unsigned        NUM_CH      = 8,
    parameter int unsigned        TIMER_W     = 6,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0]  REPEAT_MASK = NUM_CH'(8'b0000_0111),
    parameter bit                 SOCD_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  ic_if
);
    localparam int unsigned CNT_W = TIMER_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_e;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_c;
    logic [NUM_CH-1:0] eff_c;
    logic [NUM_CH-1:0] rise_c;
    logic [NUM_CH-1:0] held_q;
    logic [NUM_CH-1:0] pulse_c;
    logic [CNT_W-1:0]  das_lim_c;
    logic [CNT_W-1:0]  arr_lim_c;

    // Metastability chain on the asynchronous key levels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= ic_if.raw_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_c = sync_q[SYNC_STAGES-1];

    if (SOCD_EN && NUM_CH >= 2) begin : g_socd
        logic [1:0] sync_prev_q;
        logic [1:0] press_c;
        logic       owner_q;
        logic       owner_c;

        // Newest press of left/right takes ownership; channel 0 wins a tie
        always_comb begin
            press_c = sync_c[1:0] & ~sync_prev_q;
            owner_c = owner_q;
            if (press_c[0]) begin
                owner_c = 1'b0;
            end else if (press_c[1]) begin
                owner_c = 1'b1;
            end
            eff_c = sync_c;
            if (sync_c[1:0] == 2'b11) begin
                eff_c[1:0] = owner_c ? 2'b10 : 2'b01;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_prev_q <= '0;
                owner_q     <= 1'b0;
            end else begin
                sync_prev_q <= sync_c[1:0];
                owner_q     <= owner_c;
            end
        end
    end else begin : g_nosocd
        assign eff_c = sync_c;
    end

    // held doubles as the previous effective level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            held_q <= eff_c;
        end
    end

    assign rise_c = eff_c & ~held_q;

    // A zero configuration behaves as one tick
    assign das_lim_c = (ic_if.cfg_das_delay == '0) ? CNT_W'(1) : CNT_W'(ic_if.cfg_das_delay);
    assign arr_lim_c = (ic_if.cfg_arr == '0)       ? CNT_W'(1) : CNT_W'(ic_if.cfg_arr);

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic pulse_q;

        if (REPEAT_MASK[i]) begin : g_rep
            state_e             state_q;
            logic [TIMER_W-1:0] cnt_q;
            logic [CNT_W-1:0]   cnt_inc_c;
            logic [CNT_W-1:0]   lim_c;

            // Widened increment so the >= compare never sees a wrapped count
            assign cnt_inc_c = CNT_W'(cnt_q) + CNT_W'(1);
            assign lim_c     = (state_q == ST_REPEAT) ? arr_lim_c : das_lim_c;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= 1'b0;
                    if (ic_if.freeze || !eff_c[i]) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (rise_c[i]) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_DELAY;
                    end else if (ic_if.tick && state_q != ST_IDLE) begin
                        if (cnt_inc_c >= lim_c) begin
                            pulse_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_REPEAT;
                        end else begin
                            cnt_q <= cnt_inc_c[TIMER_W-1:0];
                        end
                    end
                end
            end
        end else begin : g_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= rise_c[i] & ~ic_if.freeze;
                end
            end
        end

        assign pulse_c[i] = pulse_q;
    end

    assign ic_if.cmd_pulse = pulse_c;
    assign ic_if.held      = held_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus a randomized run against a
// behavioural model built from presses, fire counts and ticks-since-last-fire.
module tb_input_conditioner;
    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned TIMER_W     = 6;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [7:0]  REPEAT_MASK = 8'b0000_0111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    input_conditioner_if #(.NUM_CH(NUM_CH), .TIMER_W(TIMER_W)) bus ();

    input_conditioner #(
        .NUM_CH      (NUM_CH),
        .TIMER_W     (TIMER_W),
        .SYNC_STAGES (SYNC_STAGES),
        .REPEAT_MASK (REPEAT_MASK),
        .SOCD_EN     (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ic_if (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pcnt [NUM_CH];
    logic [NUM_CH-1:0] dut_pulse, dut_held, exp_pulse, exp_held;

    // Reference model state
    logic [NUM_CH-1:0] m_pipe [$];
    logic [NUM_CH-1:0] m_prev;
    logic [1:0]        m_sprev;
    int                m_owner;
    int                m_fires [NUM_CH];
    int                m_since [NUM_CH];

    function automatic int lim(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void model_step();
        logic [NUM_CH-1:0] s, eff;
        bit pressed;
        if (rst || m_pipe.size() != SYNC_STAGES) begin
            m_pipe = {};
            for (int k = 0; k < int'(SYNC_STAGES); k++) m_pipe.push_back('0);
            m_prev = '0; m_sprev = '0; m_owner = 0;
            for (int i = 0; i < int'(NUM_CH); i++) begin m_fires[i] = 0; m_since[i] = 0; end
            exp_pulse = '0; exp_held = '0;
            if (rst) return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(bus.raw_in);
        if (s[0] && !m_sprev[0]) m_owner = 0;
        else if (s[1] && !m_sprev[1]) m_owner = 1;
        eff = s;
        if (s[0] && s[1]) begin
            eff[0] = (m_owner == 0);
            eff[1] = (m_owner == 1);
        end
        m_sprev = s[1:0];
        exp_pulse = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pressed = eff[i] && !m_prev[i];
            if (!REPEAT_MASK[i]) begin
                exp_pulse[i] = pressed && !bus.freeze;
            end else if (bus.freeze || !eff[i]) begin
                m_fires[i] = 0; m_since[i] = 0;
            end else if (pressed) begin
                exp_pulse[i] = 1'b1; m_fires[i] = 1; m_since[i] = 0;
            end else if (m_fires[i] > 0 && bus.tick) begin
                m_since[i]++;
                if (m_since[i] >= ((m_fires[i] == 1) ? lim(int'(bus.cfg_das_delay))
                                                     : lim(int'(bus.cfg_arr)))) begin
                    exp_pulse[i] = 1'b1; m_fires[i] = 2; m_since[i] = 0;
                end
            end
        end
        m_prev = eff;
        exp_held = eff;
    endfunction

    task automatic drive_cycle(input bit tk);
        bus.tick = tk;
        model_step();
        @(posedge clk);
        #1;
        dut_pulse = bus.cmd_pulse;
        dut_held  = bus.held;
        for (int i = 0; i < int'(NUM_CH); i++) pcnt[i] += int'(dut_pulse[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0);
    endtask

    task automatic run_frames(input int n, input int len);
        repeat (n) begin
            drive_cycle(1'b1);
            repeat (len - 1) drive_cycle(1'b0);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < int'(NUM_CH); i++) pcnt[i] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp++; if (dut_pulse !== '0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0", dut_pulse); end
        n_cmp++; if (dut_held !== '0) begin n_bad++; $display("FAIL reset_held: got %b expected 0", dut_held); end
        rst = 1'b0;
        bus.raw_in[0] = 1'b1;
        clear_counts(); idle(5);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL reset_first_press: got %0d pulses expected 1", pcnt[0]); end
        rst = 1'b1; idle(1);
        n_cmp++; if (dut_held !== '0 || dut_pulse !== '0) begin n_bad++; $display("FAIL reset_mid_hold: held=%b pulse=%b expected 0/0", dut_held, dut_pulse); end
        rst = 1'b0;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[0] !== 1 || dut_held[0] !== 1'b1) begin n_bad++; $display("FAIL reset_rehold_pulse: got %0d pulses held0=%b expected 1/1", pcnt[0], dut_held[0]); end
        bus.raw_in = '0; idle(4);
    endtask

    task automatic test_das();
        bus.cfg_das_delay = 6'd10; bus.cfg_arr = 6'd2;
        bus.raw_in[0] = 1'b1;
        clear_counts(); idle(3);
        run_frames(9, 4);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL das_before_delay: got %0d expected 1", pcnt[0]); end
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 2) begin n_bad++; $display("FAIL das_at_tick10: got %0d expected 2", pcnt[0]); end
        run_frames(10, 4);
        n_cmp++; if (pcnt[0] !== 7) begin n_bad++; $display("FAIL das_total_20_ticks: got %0d expected 7", pcnt[0]); end
        bus.raw_in[0] = 1'b0;
        clear_counts(); run_frames(10, 4);
        n_cmp++; if (pcnt[0] !== 0 || dut_held[0] !== 1'b0) begin n_bad++; $display("FAIL das_release: got %0d pulses held0=%b expected 0/0", pcnt[0], dut_held[0]); end
    endtask

    task automatic test_oneshot();
        bus.raw_in[4] = 1'b1;
        clear_counts(); idle(3); run_frames(100, 2);
        n_cmp++; if (pcnt[4] !== 1) begin n_bad++; $display("FAIL oneshot_hold: got %0d expected 1", pcnt[4]); end
        bus.raw_in[4] = 1'b0; idle(4);
        bus.raw_in[4] = 1'b1;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[4] !== 1) begin n_bad++; $display("FAIL oneshot_repress: got %0d expected 1", pcnt[4]); end
        bus.raw_in[4] = 1'b0; idle(4);
    endtask

    task automatic test_socd();
        bus.cfg_das_delay = 6'd2; bus.cfg_arr = 6'd1;
        bus.raw_in[0] = 1'b1;
        idle(3); run_frames(3, 4);
        bus.raw_in[1] = 1'b1;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[1] !== 1 || pcnt[0] !== 0) begin n_bad++; $display("FAIL socd_takeover: ch1=%0d ch0=%0d expected 1/0", pcnt[1], pcnt[0]); end
        n_cmp++; if (dut_held[1:0] !== 2'b10) begin n_bad++; $display("FAIL socd_held_takeover: got %b expected 10", dut_held[1:0]); end
        clear_counts(); run_frames(5, 4);
        n_cmp++; if (pcnt[0] !== 0) begin n_bad++; $display("FAIL socd_loser_silent: got %0d expected 0", pcnt[0]); end
        bus.raw_in[1] = 1'b0;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[0] !== 1 || dut_held[1:0] !== 2'b01) begin n_bad++; $display("FAIL socd_return: ch0=%0d held=%b expected 1/01", pcnt[0], dut_held[1:0]); end
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL socd_return_delay: got %0d expected 1", pcnt[0]); end
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 2) begin n_bad++; $display("FAIL socd_return_fire: got %0d expected 2", pcnt[0]); end
        bus.raw_in = '0; idle(4);
    endtask

    task automatic test_same_clk();
        bus.raw_in[1:0] = 2'b11;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[0] !== 1 || pcnt[1] !== 0) begin n_bad++; $display("FAIL same_clk_pulses: ch0=%0d ch1=%0d expected 1/0", pcnt[0], pcnt[1]); end
        n_cmp++; if (dut_held[1:0] !== 2'b01) begin n_bad++; $display("FAIL same_clk_held: got %b expected 01", dut_held[1:0]); end
        bus.raw_in = '0; idle(4);
    endtask

    task automatic test_freeze();
        bus.cfg_das_delay = 6'd2; bus.cfg_arr = 6'd2;
        bus.raw_in[0] = 1'b1;
        idle(3); run_frames(4, 4);
        bus.freeze = 1'b1;
        clear_counts(); run_frames(6, 4);
        n_cmp++; if (pcnt[0] !== 0 || dut_held[0] !== 1'b1) begin n_bad++; $display("FAIL freeze_hold: pulses=%0d held0=%b expected 0/1", pcnt[0], dut_held[0]); end
        bus.freeze = 1'b0;
        clear_counts(); run_frames(6, 4);
        n_cmp++; if (pcnt[0] !== 0) begin n_bad++; $display("FAIL unfreeze_held: got %0d expected 0", pcnt[0]); end
        bus.raw_in[0] = 1'b0; idle(4);
        bus.raw_in[0] = 1'b1;
        clear_counts(); idle(3);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL freeze_repress: got %0d expected 1", pcnt[0]); end
        bus.raw_in = '0; idle(4);
    endtask

    task automatic test_cfg();
        bus.cfg_das_delay = 6'd1; bus.cfg_arr = 6'd0;
        bus.raw_in[2] = 1'b1;
        clear_counts(); idle(3); run_frames(8, 4);
        n_cmp++; if (pcnt[2] !== 9) begin n_bad++; $display("FAIL arr_zero_every_tick: got %0d expected 9", pcnt[2]); end
        bus.raw_in = '0; idle(4);
        bus.cfg_das_delay = 6'd30; bus.cfg_arr = 6'd2;
        bus.raw_in[0] = 1'b1;
        idle(3);
        clear_counts(); run_frames(8, 4);
        n_cmp++; if (pcnt[0] !== 0) begin n_bad++; $display("FAIL das30_quiet: got %0d expected 0", pcnt[0]); end
        bus.cfg_das_delay = 6'd5;
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL das_lowered_fires: got %0d expected 1", pcnt[0]); end
        bus.raw_in = '0; idle(4);
        bus.cfg_das_delay = 6'd2;
        bus.raw_in[0] = 1'b1;
        clear_counts();
        drive_cycle(1'b0); drive_cycle(1'b0); drive_cycle(1'b1);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL rise_with_tick_pulse: got %0d expected 1", pcnt[0]); end
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 1) begin n_bad++; $display("FAIL rise_tick_not_counted: got %0d expected 1", pcnt[0]); end
        run_frames(1, 4);
        n_cmp++; if (pcnt[0] !== 2) begin n_bad++; $display("FAIL rise_tick_delay_fire: got %0d expected 2", pcnt[0]); end
        bus.raw_in = '0; idle(4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NUM_CH); i++)
                if ($urandom_range(0, 15) == 0) bus.raw_in[i] = ~bus.raw_in[i];
            if ($urandom_range(0, 149) == 0) bus.freeze = ~bus.freeze;
            if ($urandom_range(0, 99) == 0) bus.cfg_das_delay = TIMER_W'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) bus.cfg_arr = TIMER_W'($urandom_range(0, 4));
            rst = ($urandom_range(0, 399) == 0);
            drive_cycle($urandom_range(0, 3) == 0);
            n_cmp++;
            if (dut_pulse !== exp_pulse || dut_held !== exp_held) begin
                n_bad++;
                $display("FAIL rand_cycle %0d: pulse=%b held=%b expected pulse=%b held=%b",
                         c, dut_pulse, dut_held, exp_pulse, exp_held);
            end
        end
        rst = 1'b0; bus.freeze = 1'b0; bus.raw_in = '0; idle(4);
    endtask

    initial begin
        rst               = 1'b1;
        bus.tick          = 1'b0;
        bus.freeze        = 1'b0;
        bus.raw_in        = '0;
        bus.cfg_das_delay = 6'd10;
        bus.cfg_arr       = 6'd2;
        clear_counts();
        test_reset();
        test_das();
        test_oneshot();
        test_socd();
        test_same_clk();
        test_freeze();
        test_cfg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
